// File: rtl/dataflow_pkg.sv
// dataflow_pkg: shared types for the core dataflow between pipeline stages.
//   stages_t      - identifies a producing stage (trace/debug tagging)
//   *_t structs   - per-boundary stage payloads carried by pipeline_stage_reg
//   PipeMaxDepth  - most entries a single pipeline_stage_reg can hold
// The valid+payload entry type (pipe_entry_t) is width-dependent. It is
// declared inside pipeline_entry, where PayloadSize is known.
package dataflow_pkg;

    localparam int PipeMaxDepth = 2;

    typedef enum logic [2:0] {
        Fetch,
        Decode,
        Execute,
        Memory,
        Writeback
    } stages_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_t;

endpackage

// File: rtl/pipeline_entry.sv
// pipeline_entry: one valid+payload register slot.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   load         - capture data and set valid
//   clear        - drop valid (payload is kept); wins over load
//   data         - payload to capture on load
//   valid        - entry holds a live payload
//   payload      - stored payload (last loaded value, 0 after reset)
module pipeline_entry #(
    parameter int PayloadSize = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic [PayloadSize-1:0] data,
    output logic                   valid,
    output logic [PayloadSize-1:0] payload
);

    typedef struct packed {
        logic                   valid;
        logic [PayloadSize-1:0] payload;
    } pipe_entry_t;

    pipe_entry_t entry;

    always_ff @(posedge clock) begin
        if (reset) begin
            entry <= '0;
        end else if (clear) begin
            entry.valid <= 1'b0;
        end else if (load) begin
            entry.valid   <= 1'b1;
            entry.payload <= data;
        end
    end

    assign valid   = entry.valid;
    assign payload = entry.payload;

endmodule

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: elastic valid/ready register between two core stages.
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   flush                  - drop every held entry on the next edge
//   in_valid/in_ready      - upstream handshake, in_payload captured on transfer
//   out_valid/out_ready    - downstream handshake, out_ready=0 is a stall
//   out_payload            - head entry payload
//   occupancy              - live entries held (0..2)
// Build option: define PIPELINE_SKID_BUFFER_EN for a second (skid) entry and
// a registered in_ready; otherwise one entry with in_ready combinational
// from out_ready.
module pipeline_stage_reg
    import dataflow_pkg::*;
#(
    parameter int      PayloadSize = 32,
    parameter stages_t Stage       = Fetch
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PayloadSize-1:0] in_payload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PayloadSize-1:0] out_payload,
    output logic [1:0]             occupancy
);

    // Stage only tags the instance for trace tooling.
    logic [$bits(stages_t)-1:0] unused_stage;
    assign unused_stage = Stage;

    logic                   in_xfer;
    logic                   out_xfer;
    logic                   main_valid;
    logic                   main_load;
    logic                   main_clear;
    logic [PayloadSize-1:0] main_data;

    assign out_valid = main_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;

    pipeline_entry #(.PayloadSize(PayloadSize)) u_main (
        .clock   (clock),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .data    (main_data),
        .valid   (main_valid),
        .payload (out_payload)
    );

`ifdef PIPELINE_SKID_BUFFER_EN
    logic                   skid_valid;
    logic                   skid_load;
    logic                   skid_clear;
    logic [PayloadSize-1:0] skid_payload;

    // Ready comes straight off a flop: the skid slot is what lets us accept
    // the one extra beat that arrives while the stall is still propagating.
    assign in_ready = ~skid_valid;

    // Main refills from skid when draining with skid live (skid is always
    // older than any input); otherwise from the input when main is free.
    // skid_valid implies in_ready=0, so those two sources never compete.
    assign main_load  = ~flush & ((skid_valid & out_xfer) |
                                  (in_xfer & (~main_valid | out_ready)));
    assign main_data  = skid_valid ? skid_payload : in_payload;
    assign main_clear = flush | (out_xfer & ~main_load);

    // Input parks in skid only when main is full and stalled.
    assign skid_load  = ~flush & in_xfer & main_valid & ~out_ready;
    assign skid_clear = flush | (skid_valid & out_xfer);

    pipeline_entry #(.PayloadSize(PayloadSize)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .data    (in_payload),
        .valid   (skid_valid),
        .payload (skid_payload)
    );

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
    assign in_ready   = ~main_valid | out_ready;
    assign main_load  = ~flush & in_xfer;
    assign main_data  = in_payload;
    assign main_clear = flush | (out_xfer & ~in_xfer);
    assign occupancy  = {1'b0, main_valid};
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;
    import dataflow_pkg::*;

`ifdef PIPELINE_SKID_BUFFER_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_payload;
    logic [1:0]  occupancy;

    pipeline_stage_reg #(.PayloadSize(32), .Stage(Execute)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          mcnt = 0;
    bit          last_ix = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference ready: registered "fewer than two held" with skid,
    // combinational "empty or draining" without.
    function automatic bit mrdy();
        if (Skid) return (mcnt < 2);
        return (mcnt == 0) || (out_ready == 1'b1);
    endfunction

    // Drive one cycle; once the monitor has sampled, record what the
    // upstream side handed over. Returns at posedge+1.
    task automatic step(input logic iv, input logic [31:0] pl, input logic ordy,
                        input logic fl, input logic rst);
        in_valid   = iv;
        in_payload = pl;
        out_ready  = ordy;
        flush      = fl;
        reset      = rst;
        @(negedge clock);
        #2;
        last_ix = iv && mrdy() && !fl && !rst;
        if (rst || fl) exp_q.delete();
        else if (last_ix) exp_q.push_back(pl);
        mcnt = exp_q.size();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("occupancy", {30'd0, occupancy}, mcnt);
            chk("in_ready", {31'd0, in_ready}, {31'd0, mrdy()});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mcnt != 0});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h want none", out_payload);
                end else begin
                    chk("out_payload", out_payload, exp_q[0]);
                    if (out_ready && !flush && !reset) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] alist [3];
        logic [31:0] cur;
        int          idx;
        bit          iv, ordy, fl;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0; out_ready = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_out_payload", out_payload, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at full rate.
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        chk("stream_p0", out_payload, 32'h11);
        chk("stream_occ0", {30'd0, occupancy}, 32'd1);
        step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        chk("stream_p1", out_payload, 32'h22);
        chk("stream_occ1", {30'd0, occupancy}, 32'd1);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        chk("stream_p2", out_payload, 32'h33);
        chk("stream_vld2", {31'd0, out_valid}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_drained", {30'd0, occupancy}, 32'd0);

        // Stall: out_ready low for three cycles, upstream holds unaccepted data.
        alist[0] = 32'hA0; alist[1] = 32'hA1; alist[2] = 32'hA2;
        idx = 0;
        step(1'b1, alist[0], 1'b1, 1'b0, 1'b0);
        if (last_ix) idx++;
        out_ready = 1'b0;
        #1;
        chk("stall_ready_same_cycle", {31'd0, in_ready}, {31'd0, Skid});
        for (int c = 0; c < 3; c++) begin
            step(idx < 3, alist[idx < 3 ? idx : 2], 1'b0, 1'b0, 1'b0);
            if (last_ix) idx++;
        end
        chk("stall_occ", {30'd0, occupancy}, Skid ? 32'd2 : 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_head", out_payload, 32'hA0);
        for (int c = 0; c < 12 && (idx < 3 || exp_q.size() != 0); c++) begin
            step(idx < 3, alist[idx < 3 ? idx : 2], 1'b1, 1'b0, 1'b0);
            if (last_ix) idx++;
        end
        chk("stall_all_sent", idx, 32'd3);
        chk("stall_last_payload", out_payload, 32'hA2);
        chk("stall_empty", {30'd0, occupancy}, 32'd0);

        // Flush with entries held and a concurrent input that must vanish.
        step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_occ", {30'd0, occupancy}, Skid ? 32'd2 : 32'd1);
        step(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_payload_held", out_payload, 32'hB0);
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream.
        step(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
        chk("mid_occ", {30'd0, occupancy}, 32'd1);
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_occ", {30'd0, occupancy}, 32'd0);
        chk("mid_rst_payload", out_payload, 32'h0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Random handshaking; payload held until accepted.
        cur = $urandom;
        for (int c = 0; c < 10000; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 199) == 0);
            step(iv, cur, ordy, fl, 1'b0);
            if (last_ix) cur = $urandom;
        end

        // Drain whatever remains.
        for (int c = 0; c < 4 && exp_q.size() != 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("final_empty", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
